clip_control_fsm: RTL and testbench
===================================

// Module: clip_control_fsm
// PURPOSE
//  Front-panel input side of the clip recorder. Takes raw push-buttons, synchronises and
//  debounces them, and runs the record/play state machine. Produces clip_num and
//  record_or_play for the seven-segment/LED display driver and the audio engine.
//  Also tracks which clips hold a recording and bounds every take with a timeout.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive identical samples required to accept a new button level
//  MAX_CLIP_CYCLES  1000000  maximum record/play duration in clocks; forced stop when reached
// PORTS
//  clock           in   1  system clock, all logic on posedge
//  reset           in   1  synchronous, active-high; clears all state
//  btn_clip        in   1  raw, asynchronous; toggles selected clip
//  btn_record      in   1  raw, asynchronous; start recording selected clip
//  btn_play        in   1  raw, asynchronous; start playback of selected clip
//  btn_stop        in   1  raw, asynchronous; end current record/play
//  play_done       in   1  one-cycle pulse from audio engine: playback data exhausted
//  clip_num        out  1  selected clip (0 = clip 1, 1 = clip 2)
//  record_or_play  out  1  1 = record, 0 = play; holds last mode while idle
//  active          out  1  high while in RECORD or PLAY
//  start_pulse     out  1  one-cycle pulse on entry to RECORD/PLAY
//  stop_pulse      out  1  one-cycle pulse on return to IDLE
//  clip_recorded   out  2  bit n set once clip n has completed a recording
// BEHAVIOUR
//  - Reset values: clip_num=0, record_or_play=0, active=0, start_pulse=0, stop_pulse=0,
//    clip_recorded=2'b00, timer=0, FSM=IDLE, debounced levels=0.
//    Reset mid-take aborts without stop_pulse and without setting clip_recorded.
//  - Per button: 2-flop synchroniser, then debounce counter. The counter restarts on any
//    sample differing from the accepted level. The new level is accepted on the
//    DEBOUNCE_CYCLES-th consecutive differing sample.
//    The rising edge of the accepted level gives a one-cycle press pulse. Latency from a
//    stable raw edge to the press pulse is 2+DEBOUNCE_CYCLES+1 clocks.
//  - All outputs are registered. FSM reacts to a press pulse in the following cycle.
//  - FSM states: IDLE, RECORD, PLAY.
//    IDLE, presses evaluated with priority stop > record > play > clip, one action per cycle:
//      * stop: ignored.
//      * record: go to RECORD; record_or_play=1; active=1; start_pulse; timer=0.
//      * play: if clip_recorded[clip_num], go to PLAY; record_or_play=0; active=1;
//        start_pulse; timer=0. Otherwise ignored, no state change.
//      * clip: clip_num toggles (wraps 1->0).
//    RECORD / PLAY: timer increments each cycle, width $clog2(MAX_CLIP_CYCLES).
//      End condition is any of: stop press, timer==MAX_CLIP_CYCLES-1, or play_done (PLAY
//      only; ignored in RECORD). On end: go to IDLE; active=0; stop_pulse; timer=0.
//      Leaving RECORD sets clip_recorded[clip_num].
//      clip, record and play presses are ignored while active. clip_num is frozen.
//  - Simultaneous end conditions produce exactly one stop_pulse.
//  - start_pulse and stop_pulse never assert in the same cycle. IDLE->active->IDLE takes
//    at least 2 cycles.
// STRUCTURE
//  - Package clip_ctrl_pkg: typedef enum logic[1:0] {IDLE, RECORD, PLAY} clip_state_t;
//    localparams CLIP1=1'b0, CLIP2=1'b1, MODE_PLAY=1'b0, MODE_RECORD=1'b1.
//  - Sub-module button_debouncer #(DEBOUNCE_CYCLES) (clock, reset, raw, level, press).
//    Instantiated four times.
//  - Top holds the FSM, timer, clip_num and clip_recorded registers.
// TESTING (DEBOUNCE_CYCLES=4, MAX_CLIP_CYCLES=16)
//  1. Hold btn_clip high 20 clks -> exactly one toggle, clip_num 0->1, press seen 7 clks
//     after the raw edge. A 3-clock glitch -> no toggle.
//  2. Reset, press play -> no start_pulse, active stays 0 (clip_recorded=00).
//  3. Record clip 0, stop after 5 clks -> start_pulse, then stop_pulse; clip_recorded=01;
//     record_or_play stays 1.
//  4. Play clip 0 with no stop -> stop_pulse forced when timer hits 15; then btn_play
//     restarts the take. Play again with play_done pulse -> immediate stop_pulse.
//  5. In RECORD, press btn_clip and btn_play -> clip_num and mode unchanged.
//     Assert reset mid-take -> all outputs at reset values, clip_recorded=00.
//  6. In IDLE, press stop+record+clip in the same cycle -> nothing.
//     Press record+play+clip in the same cycle -> RECORD entered, clip_num unchanged.

Source files
------------

// File: rtl/clip_ctrl_pkg.sv
// Shared types and constants for the clip recorder front-panel control.
package clip_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } clip_state_t;

    localparam logic CLIP1       = 1'b0;
    localparam logic CLIP2       = 1'b1;
    localparam logic MODE_PLAY   = 1'b0;
    localparam logic MODE_RECORD = 1'b1;

    // One-hot mask selecting the clip_recorded bit that belongs to a clip.
    function automatic logic [1:0] clip_mask(input logic clip);
        logic [1:0] mask;
        if (clip == CLIP2) begin
            mask = 2'b10;
        end else begin
            mask = 2'b01;
        end
        return mask;
    endfunction

endpackage

// File: rtl/clip_control_fsm_if.sv
// Front-panel bundle: raw buttons and audio-engine status in, display/engine controls out.
interface clip_control_fsm_if;
    logic       btn_clip;
    logic       btn_record;
    logic       btn_play;
    logic       btn_stop;
    logic       play_done;
    logic       clip_num;
    logic       record_or_play;
    logic       active;
    logic       start_pulse;
    logic       stop_pulse;
    logic [1:0] clip_recorded;

    modport master (
        output btn_clip, btn_record, btn_play, btn_stop, play_done,
        input  clip_num, record_or_play, active, start_pulse, stop_pulse, clip_recorded
    );

    modport slave (
        input  btn_clip, btn_record, btn_play, btn_stop, play_done,
        output clip_num, record_or_play, active, start_pulse, stop_pulse, clip_recorded
    );
endinterface

// File: rtl/clip_control_fsm_button_debouncer.sv
// Two-flop synchroniser, level debouncer and registered rising-edge press detector
// for one raw push-button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= r_level;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_level <= r_level;
        end
    end

    // Registered one-cycle pulse on each rising edge of the accepted level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/clip_control_fsm.sv
// Record/play control for the two-clip recorder: debounced buttons drive an
// IDLE/RECORD/PLAY machine with a per-take timeout and a recorded-clip map.
module clip_control_fsm
    import clip_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_CLIP_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    clip_control_fsm_if.slave  bus
);

    localparam int TIMER_W = $clog2(MAX_CLIP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MAX_CLIP_CYCLES - 1);

    logic w_level_clip, w_level_record, w_level_play, w_level_stop;
    logic w_press_clip, w_press_record, w_press_play, w_press_stop;
    logic w_unused_levels;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clip (
        .clock(clock), .reset(reset), .raw(bus.btn_clip),
        .level(w_level_clip), .press(w_press_clip)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_record (
        .clock(clock), .reset(reset), .raw(bus.btn_record),
        .level(w_level_record), .press(w_press_record)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clock(clock), .reset(reset), .raw(bus.btn_play),
        .level(w_level_play), .press(w_press_play)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clock(clock), .reset(reset), .raw(bus.btn_stop),
        .level(w_level_stop), .press(w_press_stop)
    );

    // The FSM acts on presses only; held levels carry no meaning here.
    assign w_unused_levels = ^{w_level_clip, w_level_record, w_level_play, w_level_stop};

    clip_state_t        r_state,    w_state_nx;
    logic [TIMER_W-1:0] r_timer,    w_timer_nx;
    logic               r_clip_num, w_clip_nx;
    logic               r_mode,     w_mode_nx;
    logic               r_active,   w_active_nx;
    logic               r_start,    w_start_nx;
    logic               r_stop,     w_stop_nx;
    logic [1:0]         r_recorded, w_recorded_nx;
    logic               w_timer_last;

    assign w_timer_last = (r_timer == TIMER_LAST);

    // Next-state and next-output decode; one action per cycle in IDLE.
    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer;
        w_clip_nx     = r_clip_num;
        w_mode_nx     = r_mode;
        w_active_nx   = r_active;
        w_start_nx    = 1'b0;
        w_stop_nx     = 1'b0;
        w_recorded_nx = r_recorded;
        case (r_state)
            IDLE: begin
                if (w_press_stop) begin
                    w_state_nx = IDLE;
                end else if (w_press_record) begin
                    w_state_nx  = RECORD;
                    w_mode_nx   = MODE_RECORD;
                    w_active_nx = 1'b1;
                    w_start_nx  = 1'b1;
                    w_timer_nx  = {TIMER_W{1'b0}};
                end else if (w_press_play) begin
                    if ((r_recorded & clip_mask(r_clip_num)) != 2'b00) begin
                        w_state_nx  = PLAY;
                        w_mode_nx   = MODE_PLAY;
                        w_active_nx = 1'b1;
                        w_start_nx  = 1'b1;
                        w_timer_nx  = {TIMER_W{1'b0}};
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else if (w_press_clip) begin
                    w_clip_nx = ~r_clip_num;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RECORD: begin
                w_timer_nx = r_timer + TIMER_W'(1);
                if (w_press_stop || w_timer_last) begin
                    w_state_nx    = IDLE;
                    w_active_nx   = 1'b0;
                    w_stop_nx     = 1'b1;
                    w_timer_nx    = {TIMER_W{1'b0}};
                    w_recorded_nx = r_recorded | clip_mask(r_clip_num);
                end else begin
                    w_state_nx = RECORD;
                end
            end
            PLAY: begin
                w_timer_nx = r_timer + TIMER_W'(1);
                if (w_press_stop || w_timer_last || bus.play_done) begin
                    w_state_nx  = IDLE;
                    w_active_nx = 1'b0;
                    w_stop_nx   = 1'b1;
                    w_timer_nx  = {TIMER_W{1'b0}};
                end else begin
                    w_state_nx = PLAY;
                end
            end
            default: begin
                w_state_nx  = IDLE;
                w_active_nx = 1'b0;
                w_timer_nx  = {TIMER_W{1'b0}};
            end
        endcase
    end

    // State, timer and registered outputs; reset abandons any take silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_timer    <= {TIMER_W{1'b0}};
            r_clip_num <= CLIP1;
            r_mode     <= MODE_PLAY;
            r_active   <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_recorded <= 2'b00;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_clip_num <= w_clip_nx;
            r_mode     <= w_mode_nx;
            r_active   <= w_active_nx;
            r_start    <= w_start_nx;
            r_stop     <= w_stop_nx;
            r_recorded <= w_recorded_nx;
        end
    end

    assign bus.clip_num       = r_clip_num;
    assign bus.record_or_play = r_mode;
    assign bus.active         = r_active;
    assign bus.start_pulse    = r_start;
    assign bus.stop_pulse     = r_stop;
    assign bus.clip_recorded  = r_recorded;

endmodule

// File: tb/tb_clip_control_fsm.sv
// Scoreboard bench for clip_control_fsm with DEBOUNCE_CYCLES=4, MAX_CLIP_CYCLES=16.
// Each button driven at cycle k produces its press at edge k+7 and the FSM
// reaction (pulse visible) at cycle k+8.
module tb_clip_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        bit         is_start;
        int         at;
        bit         cn;
        bit         md;
        logic [1:0] rec;
    } ev_t;

    ev_t exp_q[$];

    localparam logic [3:0] B_CLIP = 4'b0001;
    localparam logic [3:0] B_REC  = 4'b0010;
    localparam logic [3:0] B_PLAY = 4'b0100;
    localparam logic [3:0] B_STOP = 4'b1000;

    clip_control_fsm_if bus();

    clip_control_fsm #(.DEBOUNCE_CYCLES(4), .MAX_CLIP_CYCLES(16)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compares {clip_num, mode, active, start, stop, clip_recorded}; pulses expected low.
    task automatic check_state(input string name, input logic cn, input logic md,
                               input logic ac, input logic [1:0] rec);
        check(name,
              64'({bus.clip_num, bus.record_or_play, bus.active,
                   bus.start_pulse, bus.stop_pulse, bus.clip_recorded}),
              64'({cn, md, ac, 1'b0, 1'b0, rec}));
    endtask

    task automatic push_ev(input bit is_start, input int at, input bit cn,
                           input bit md, input logic [1:0] rec);
        ev_t e;
        e.is_start = is_start;
        e.at       = at;
        e.cn       = cn;
        e.md       = md;
        e.rec      = rec;
        exp_q.push_back(e);
    endtask

    task automatic set_btns(input logic [3:0] m);
        bus.btn_clip   = m[0];
        bus.btn_record = m[1];
        bus.btn_play   = m[2];
        bus.btn_stop   = m[3];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every start/stop pulse is matched against the next expected event.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (bus.start_pulse && bus.stop_pulse) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_overlap: start and stop both high at cycle %0d", cyc);
        end else if (bus.start_pulse || bus.stop_pulse) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: start=%0b stop=%0b at cycle %0d, none expected",
                         bus.start_pulse, bus.stop_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                check(e.is_start ? "start_event" : "stop_event",
                      64'({bus.start_pulse, cyc, bus.clip_num, bus.record_or_play,
                           bus.active, bus.clip_recorded}),
                      64'({e.is_start, e.at, e.cn, e.md, e.is_start, e.rec}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        int k;
        set_btns(4'b0000);
        bus.play_done = 1'b0;
        rst = 1'b1;
        step(3);
        check_state("reset_values", 1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        step(1);

        // 1. Debounced clip toggle with latency, then a short glitch.
        k = cyc;
        set_btns(B_CLIP);
        step(7);
        check_state("clip_before_press", 1'b0, 1'b0, 1'b0, 2'b00);
        step(1);
        check_state("clip_toggle_latency", 1'b1, 1'b0, 1'b0, 2'b00);
        step(12);
        set_btns(4'b0000);
        step(10);
        check_state("clip_single_toggle", 1'b1, 1'b0, 1'b0, 2'b00);
        set_btns(B_CLIP);
        step(3);
        set_btns(4'b0000);
        step(12);
        check_state("clip_glitch_ignored", 1'b1, 1'b0, 1'b0, 2'b00);

        // 2. Reset, then play with nothing recorded.
        rst = 1'b1;
        step(2);
        check_state("reset_clears_clip", 1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        step(1);
        set_btns(B_PLAY);
        step(10);
        set_btns(4'b0000);
        step(10);
        check_state("play_unrecorded", 1'b0, 1'b0, 1'b0, 2'b00);

        // 3. Record clip 0, stop 5 cycles after start.
        k = cyc;
        set_btns(B_REC);
        push_ev(1'b1, k + 8, 1'b0, 1'b1, 2'b00);
        step(5);
        set_btns(B_REC | B_STOP);
        push_ev(1'b0, k + 13, 1'b0, 1'b1, 2'b01);
        step(5);
        set_btns(B_STOP);
        step(5);
        set_btns(4'b0000);
        step(10);
        check_state("after_record_clip1", 1'b0, 1'b1, 1'b0, 2'b01);

        // 4. Play clip 0 into the timeout, then again ended by play_done.
        k = cyc;
        set_btns(B_PLAY);
        push_ev(1'b1, k + 8, 1'b0, 1'b0, 2'b01);
        push_ev(1'b0, k + 24, 1'b0, 1'b0, 2'b01);
        step(10);
        set_btns(4'b0000);
        step(20);
        check_state("play_timeout", 1'b0, 1'b0, 1'b0, 2'b01);
        k = cyc;
        set_btns(B_PLAY);
        push_ev(1'b1, k + 8, 1'b0, 1'b0, 2'b01);
        step(10);
        set_btns(4'b0000);
        step(2);
        bus.play_done = 1'b1;
        push_ev(1'b0, k + 13, 1'b0, 1'b0, 2'b01);
        step(1);
        bus.play_done = 1'b0;
        step(10);
        check_state("play_done_stop", 1'b0, 1'b0, 1'b0, 2'b01);

        // 5. Select clip 2, record it; clip/play/play_done ignored while recording.
        set_btns(B_CLIP);
        step(10);
        set_btns(4'b0000);
        step(10);
        check_state("select_clip2", 1'b1, 1'b0, 1'b0, 2'b01);
        k = cyc;
        set_btns(B_REC);
        push_ev(1'b1, k + 8, 1'b1, 1'b1, 2'b01);
        step(10);
        set_btns(B_CLIP | B_PLAY);
        step(2);
        bus.play_done = 1'b1;
        step(1);
        bus.play_done = 1'b0;
        step(1);
        set_btns(B_CLIP | B_PLAY | B_STOP);
        push_ev(1'b0, k + 22, 1'b1, 1'b1, 2'b11);
        step(6);
        check_state("frozen_in_record", 1'b1, 1'b1, 1'b1, 2'b01);
        set_btns(4'b0000);
        step(12);
        check_state("after_record_clip2", 1'b1, 1'b1, 1'b0, 2'b11);

        // Reset in the middle of a take: no stop pulse, map cleared.
        k = cyc;
        set_btns(B_REC);
        push_ev(1'b1, k + 8, 1'b1, 1'b1, 2'b11);
        step(10);
        set_btns(4'b0000);
        step(2);
        rst = 1'b1;
        step(1);
        check_state("reset_mid_take", 1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        step(15);
        check_state("after_abort", 1'b0, 1'b0, 1'b0, 2'b00);

        // 6. Simultaneous presses: stop wins (nothing), then record beats play/clip.
        set_btns(B_STOP | B_REC | B_CLIP);
        step(10);
        set_btns(4'b0000);
        step(12);
        check_state("stop_priority", 1'b0, 1'b0, 1'b0, 2'b00);
        k = cyc;
        set_btns(B_REC | B_PLAY | B_CLIP);
        push_ev(1'b1, k + 8, 1'b0, 1'b1, 2'b00);
        step(10);
        check_state("record_priority", 1'b0, 1'b1, 1'b1, 2'b00);
        set_btns(B_STOP);
        push_ev(1'b0, k + 18, 1'b0, 1'b1, 2'b01);
        step(10);
        set_btns(4'b0000);
        step(10);
        check_state("after_priority_take", 1'b0, 1'b1, 1'b0, 2'b01);

        step(5);
        check("events_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
